// File: rtl/k6502_seq.sv
// k6502 instruction sequencer: latches opcodes into ir and steps a one-hot cycle counter for the microcode ROM.
// Optional retired-instruction counter enabled by defining K6502_SEQ_ICOUNT_EN.
module k6502_seq #(
  parameter logic [7:0] RESET_OPCODE = 8'h00,
  parameter int         ICOUNT_W     = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rdy,
  input  logic [7:0]          data_in,
  input  logic                sync_next,
  output logic [7:0]          ir,
  output logic [5:0]          cycle,
  output logic                sync,
  output logic                halt,
  output logic [ICOUNT_W-1:0] icount
);

  typedef enum logic [1:0] {
    S_RST  = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  ir_nxt;
  logic [5:0]  cycle_nxt;
  logic        halt_nxt;

  assign sync = rdy & sync_next & (state != S_HALT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_RST;
      ir    <= RESET_OPCODE;
      cycle <= 6'b000000;
      halt  <= 1'b0;
    end else begin
      state <= state_nxt;
      ir    <= ir_nxt;
      cycle <= cycle_nxt;
      halt  <= halt_nxt;
    end
  end

  // A load always wins over the C_5 trap; rdy=0 freezes everything, trap detection included.
  always_comb begin
    state_nxt = state;
    ir_nxt    = ir;
    cycle_nxt = cycle;
    halt_nxt  = halt;
    if (rdy) begin
      case (state)
        S_RST: begin
          if (sync_next) begin
            ir_nxt    = data_in;
            cycle_nxt = 6'b000001;
            state_nxt = S_RUN;
          end
        end
        S_RUN: begin
          if (sync_next) begin
            ir_nxt    = data_in;
            cycle_nxt = 6'b000001;
          end else if (cycle[5]) begin
            state_nxt = S_HALT;
            halt_nxt  = 1'b1;
          end else begin
            cycle_nxt = {cycle[4:0], 1'b0};
          end
        end
        S_HALT: begin
          state_nxt = S_HALT;
        end
        default: begin
          state_nxt = S_HALT;
          halt_nxt  = 1'b1;
        end
      endcase
    end
  end

`ifdef K6502_SEQ_ICOUNT_EN
  logic [ICOUNT_W-1:0] icount_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      icount_q <= '0;
    end else if (sync && (state == S_RUN)) begin
      icount_q <= icount_q + ICOUNT_W'(1);
    end
  end

  assign icount = icount_q;
`else
  assign icount = '0;
`endif

endmodule

// File: tb/tb_k6502_seq.sv
// Scoreboard bench for k6502_seq: stimulus queues expected post-edge state, a monitor checks after each rising edge.
module tb_k6502_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       rdy;
  logic [7:0] data_in;
  logic       sync_next;
  logic [7:0] ir;
  logic [5:0] cycle;
  logic       sync;
  logic       halt;
  logic [3:0] icount;

  int vectors    = 0;
  int miscompares = 0;

  typedef struct {
    logic [7:0] ir;
    logic [5:0] cyc;
    logic       halt;
    logic [3:0] ic;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] exp_ic = 4'h0;

  k6502_seq #(.RESET_OPCODE(8'h00), .ICOUNT_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .rdy       (rdy),
    .data_in   (data_in),
    .sync_next (sync_next),
    .ir        (ir),
    .cycle     (cycle),
    .sync      (sync),
    .halt      (halt),
    .icount    (icount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  // Drive one cycle of inputs, check combinational sync, queue the state expected after the edge.
  task automatic step(input logic r, input logic sn, input logic [7:0] d,
                      input logic [7:0] eir, input logic [5:0] ecyc, input logic ehalt,
                      input logic esync, input logic cnt);
    exp_t e;
    @(negedge clk);
    rdy = r; sync_next = sn; data_in = d;
    #1;
    chk("sync", {31'd0, sync}, {31'd0, esync});
`ifdef K6502_SEQ_ICOUNT_EN
    if (cnt) exp_ic = exp_ic + 4'h1;
`endif
    e.ir = eir; e.cyc = ecyc; e.halt = ehalt; e.ic = exp_ic;
    exp_q.push_back(e);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("ir",     {24'd0, ir},     {24'd0, e.ir});
      chk("cycle",  {26'd0, cycle},  {26'd0, e.cyc});
      chk("halt",   {31'd0, halt},   {31'd0, e.halt});
      chk("icount", {28'd0, icount}, {28'd0, e.ic});
    end
  end

  task automatic reset_check(input string nm);
    chk({nm, "_ir"},     {24'd0, ir},     32'h00);
    chk({nm, "_cycle"},  {26'd0, cycle},  32'h00);
    chk({nm, "_halt"},   {31'd0, halt},   32'h0);
    chk({nm, "_icount"}, {28'd0, icount}, 32'h0);
  endtask

  // Asynchronous reset asserted between edges, checked before any clock edge.
  task automatic async_reset(input string nm);
    @(posedge clk);
    #3;
    reset = 1'b1; rdy = 1'b1; sync_next = 1'b1; data_in = 8'h55;
    exp_ic = 4'h0;
    #1;
    reset_check(nm);
    chk({nm, "_sync_in_reset"}, {31'd0, sync}, 32'h1);
    @(negedge clk);
    reset = 1'b0; rdy = 1'b0; sync_next = 1'b0;
  endtask

  initial begin
    reset = 1'b1; rdy = 1'b0; sync_next = 1'b0; data_in = 8'h00;
    #2;
    reset_check("por");
    chk("por_sync", {31'd0, sync}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // First load out of reset (not counted), then a 2-cycle NOP
    step(1, 1, 8'hEA, 8'hEA, 6'b000001, 0, 1, 0);
    step(1, 0, 8'h00, 8'hEA, 6'b000010, 0, 0, 0);
    // JMP abs: 3 cycles, then LDA # loaded at C_2
    step(1, 1, 8'h4C, 8'h4C, 6'b000001, 0, 1, 1);
    step(1, 0, 8'h11, 8'h4C, 6'b000010, 0, 0, 0);
    step(1, 0, 8'h22, 8'h4C, 6'b000100, 0, 0, 0);
    step(1, 1, 8'hA9, 8'hA9, 6'b000001, 0, 1, 1);
    step(1, 0, 8'h33, 8'hA9, 6'b000010, 0, 0, 0);
    // JMP ind with a 3-cycle bus stall during C_1
    step(1, 1, 8'h6C, 8'h6C, 6'b000001, 0, 1, 1);
    step(1, 0, 8'h44, 8'h6C, 6'b000010, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 8'hFF, 8'h6C, 6'b000010, 0, 0, 0);
    step(1, 0, 8'h44, 8'h6C, 6'b000100, 0, 0, 0);
    step(1, 0, 8'h44, 8'h6C, 6'b001000, 0, 0, 0);
    // Runaway opcode 02: walks to C_5 then traps
    step(1, 1, 8'h02, 8'h02, 6'b000001, 0, 1, 1);
    step(1, 0, 8'h00, 8'h02, 6'b000010, 0, 0, 0);
    step(1, 0, 8'h00, 8'h02, 6'b000100, 0, 0, 0);
    step(1, 0, 8'h00, 8'h02, 6'b001000, 0, 0, 0);
    step(1, 0, 8'h00, 8'h02, 6'b010000, 0, 0, 0);
    step(1, 0, 8'h00, 8'h02, 6'b100000, 0, 0, 0);
    step(1, 0, 8'h00, 8'h02, 6'b100000, 1, 0, 0);
    step(1, 1, 8'hEA, 8'h02, 6'b100000, 1, 0, 0);
    step(1, 1, 8'hEA, 8'h02, 6'b100000, 1, 0, 0);
    async_reset("halt_clear");

    // Load exactly at C_5 takes priority over the trap
    step(1, 1, 8'hEA, 8'hEA, 6'b000001, 0, 1, 0);
    step(1, 1, 8'hB1, 8'hB1, 6'b000001, 0, 1, 1);
    step(1, 0, 8'h00, 8'hB1, 6'b000010, 0, 0, 0);
    step(1, 0, 8'h00, 8'hB1, 6'b000100, 0, 0, 0);
    step(1, 0, 8'h00, 8'hB1, 6'b001000, 0, 0, 0);
    step(1, 0, 8'h00, 8'hB1, 6'b010000, 0, 0, 0);
    step(1, 0, 8'h00, 8'hB1, 6'b100000, 0, 0, 0);
    step(1, 1, 8'hA9, 8'hA9, 6'b000001, 0, 1, 1);
    step(1, 0, 8'h00, 8'hA9, 6'b000010, 0, 0, 0);
    // Reset in the middle of C_3
    step(1, 1, 8'h6D, 8'h6D, 6'b000001, 0, 1, 1);
    step(1, 0, 8'h00, 8'h6D, 6'b000010, 0, 0, 0);
    step(1, 0, 8'h00, 8'h6D, 6'b000100, 0, 0, 0);
    step(1, 0, 8'h00, 8'h6D, 6'b001000, 0, 0, 0);
    async_reset("mid_c3");

    // 17 back-to-back 2-cycle instructions: 1 uncounted load + 16 counted wraps a 4-bit icount to 0
    step(1, 1, 8'hEA, 8'hEA, 6'b000001, 0, 1, 0);
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 8'h00, (i == 0) ? 8'hEA : 8'(8'h10 + i - 1), 6'b000010, 0, 0, 0);
      step(1, 1, 8'(8'h10 + i), 8'(8'h10 + i), 6'b000001, 0, 1, 1);
    end
    step(1, 0, 8'h00, 8'h1F, 6'b000010, 0, 0, 0);

    repeat (3) @(posedge clk);
    #2;
    chk("icount_final", {28'd0, icount}, 32'h0);
    chk("queue_drain", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
